// File: rtl/fbcpu_prog_loader.sv
// Program loader for the FB-CPU block RAM: streams a program into RAM, reads it
// back to confirm the checksum, and only then releases the CPU from reset.
module fbcpu_prog_loader #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10,
    parameter int MEM_DEPTH     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [ADDRESS_WIDTH:0]   i_len,
    input  logic                     i_valid,
    input  logic [DATA_WIDTH-1:0]    i_data,
    output logic                     o_ready,
    output logic                     o_we,
    output logic [ADDRESS_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0]    o_wdata,
    input  logic [DATA_WIDTH-1:0]    i_rd_data,
    output logic                     o_cpu_rst,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err,
    output logic [DATA_WIDTH-1:0]    o_checksum
);

    localparam int LW = ADDRESS_WIDTH + 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_RUN,
        S_FAIL
    } state_t;

    state_t                   state_q, state_d;
    logic [LW-1:0]            len_q, len_d;
    logic [LW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]            vcnt_q, vcnt_d;
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    checksum_q, checksum_d;
    logic [DATA_WIDTH-1:0]    vsum_q, vsum_d;
    logic                     cpu_rst_q, cpu_rst_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     len_ok;
    logic                     accept;

    assign o_ready    = (state_q == S_LOAD) && (wr_ptr_q < len_q);
    assign len_ok     = (i_len != '0) && (i_len <= MAX_LEN);
    assign accept     = o_ready && i_valid;

    assign o_we       = we_q;
    assign o_addr     = addr_q;
    assign o_wdata    = wdata_q;
    assign o_checksum = checksum_q;
    assign o_cpu_rst  = cpu_rst_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wr_ptr_d   = wr_ptr_q;
        vcnt_d     = vcnt_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        checksum_d = checksum_q;
        vsum_d     = vsum_q;

        case (state_q)
            S_IDLE, S_RUN, S_FAIL: begin
                if (i_start) begin
                    if (len_ok) begin
                        state_d    = S_LOAD;
                        len_d      = i_len;
                        wr_ptr_d   = '0;
                        vcnt_d     = '0;
                        checksum_d = '0;
                        vsum_d     = '0;
                    end else begin
                        state_d = S_FAIL;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    we_d       = 1'b1;
                    addr_d     = wr_ptr_q[ADDRESS_WIDTH-1:0];
                    wdata_d    = i_data;
                    checksum_d = checksum_q + i_data;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                end else if (we_q && (wr_ptr_q == len_q)) begin
                    // Last word's write cycle is ending; VERIFY cycle 0 reads address 0.
                    state_d = S_VERIFY;
                    addr_d  = '0;
                    vcnt_d  = '0;
                end
            end
            S_VERIFY: begin
                // Read data lags the address by one cycle, so cycle j sees word j-1.
                vcnt_d = vcnt_q + 1'b1;
                addr_d = ADDRESS_WIDTH'(vcnt_q + 1'b1);
                if (vcnt_q == len_q) begin
                    state_d = ((vsum_q + i_rd_data) == checksum_q) ? S_RUN : S_FAIL;
                end else if (vcnt_q != '0) begin
                    vsum_d = vsum_q + i_rd_data;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d    = (state_d == S_LOAD) || (state_d == S_VERIFY);
        done_d    = (state_d == S_RUN);
        err_d     = (state_d == S_FAIL);
        cpu_rst_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            wr_ptr_q   <= '0;
            vcnt_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            checksum_q <= '0;
            vsum_q     <= '0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wr_ptr_q   <= wr_ptr_d;
            vcnt_q     <= vcnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            checksum_q <= checksum_d;
            vsum_q     <= vsum_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_fbcpu_prog_loader.sv
// Bench for fbcpu_prog_loader: a behavioural RAM plus a list-based reference
// model of the expected writes, checksum, verify outcome and decision timing.
module tb_fbcpu_prog_loader;

    localparam int AW    = 6;
    localparam int DW    = 10;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_start = 1'b0;
    logic [AW:0]   i_len = '0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [DW-1:0] i_rd_data;
    logic          o_ready, o_we, o_cpu_rst, o_busy, o_done, o_err;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata, o_checksum;

    fbcpu_prog_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_len     (i_len),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .o_ready   (o_ready),
        .o_we      (o_we),
        .o_addr    (o_addr),
        .o_wdata   (o_wdata),
        .i_rd_data (i_rd_data),
        .o_cpu_rst (o_cpu_rst),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err     (o_err),
        .o_checksum(o_checksum)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // RAM with a registered read; optional corruption of the word read from address 1.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_q = '0;
    logic [AW-1:0] rd_addr_q = '0;
    bit            corrupt = 1'b0;

    always @(posedge clk) begin
        if (o_we) mem[o_addr] <= o_wdata;
        rd_q      <= mem[o_addr];
        rd_addr_q <= o_addr;
    end
    assign i_rd_data = (corrupt && rd_addr_q == AW'(1)) ? '0 : rd_q;

    int wr_addr_log[$];
    int wr_data_log[$];
    int wr_edge_log[$];
    int ready_cnt = 0;
    int we_cnt    = 0;

    always @(negedge clk) begin
        if (o_we) begin
            wr_addr_log.push_back(int'(o_addr));
            wr_data_log.push_back(int'(o_wdata));
            wr_edge_log.push_back(edge_cnt);
            we_cnt = we_cnt + 1;
        end
        if (o_ready) ready_cnt = ready_cnt + 1;
    end

    logic [DW-1:0] wbuf [DEPTH];
    int            acc_edge [DEPTH];
    bit            pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check_eq(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // mode 0: back-to-back, 1: fixed 1,0,0,1,0,1 valid pattern, 2: random gaps
    task automatic run_load(input int len, input int mode, input bit cor, input string name);
        int  base, k, cyc, last_acc, sum, vs, nwr, dec_edge, pi;
        bit  v, rdy, got_dec, exp_pass;
        base = wr_addr_log.size();
        sum = 0;
        vs  = 0;
        for (int j = 0; j < len; j++) begin
            sum = (sum + int'(wbuf[j])) % 1024;
            if (!(cor && j == 1)) vs = (vs + int'(wbuf[j])) % 1024;
        end
        exp_pass = (vs == sum);

        @(negedge clk);
        i_start = 1'b1;
        i_len   = (AW+1)'(len);
        corrupt = cor;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        check_eq({name, "_busy_on_entry"}, o_busy, 1);
        check_eq({name, "_cpu_rst_on_entry"}, o_cpu_rst, 1);
        check_eq({name, "_ready_on_entry"}, o_ready, 1);
        check_eq({name, "_done_on_entry"}, o_done, 0);

        k = 0; cyc = 0; pi = 0; last_acc = 0;
        while (k < len && cyc < 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       begin v = pat[pi % 6]; pi++; end
                default: v = ($urandom_range(0, 9) < 7);
            endcase
            i_valid = v;
            i_data  = v ? wbuf[k] : DW'($urandom);
            rdy     = o_ready;
            @(posedge clk);
            @(negedge clk);
            if (v && rdy) begin
                acc_edge[k] = edge_cnt;
                last_acc    = edge_cnt;
                k++;
            end
            cyc++;
        end
        check_eq({name, "_accepted"}, k, len);

        // Keep offering junk words; none may be accepted once the program is in.
        i_valid = 1'b1;
        i_data  = DW'($urandom);
        got_dec = 1'b0; cyc = 0; dec_edge = 0;
        while (!got_dec && cyc < 400) begin
            if (o_done || o_err) begin
                got_dec  = 1'b1;
                dec_edge = edge_cnt;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        i_valid = 1'b0;
        corrupt = 1'b0;

        check_eq({name, "_decision_reached"}, got_dec, 1);
        check_eq({name, "_decision_latency"}, dec_edge - last_acc, len + 2);
        check_eq({name, "_done"}, o_done, exp_pass);
        check_eq({name, "_err"}, o_err, !exp_pass);
        check_eq({name, "_cpu_rst"}, o_cpu_rst, !exp_pass);
        check_eq({name, "_busy_after"}, o_busy, 0);
        check_eq({name, "_checksum"}, o_checksum, sum);

        nwr = wr_addr_log.size() - base;
        check_eq({name, "_write_count"}, nwr, len);
        for (int j = 0; j < len && j < nwr; j++) begin
            check_eq({name, "_wr_addr"}, wr_addr_log[base + j], j);
            check_eq({name, "_wr_data"}, wr_data_log[base + j], int'(wbuf[j]));
            check_eq({name, "_wr_edge"}, wr_edge_log[base + j], acc_edge[j]);
        end
        for (int j = 0; j < len; j++) check_eq({name, "_ram"}, mem[j], wbuf[j]);

        $display("load %s len=%0d mode=%0d corrupt=%0d checksum=%0d outcome=%s",
                 name, len, mode, cor, sum, exp_pass ? "run" : "halt");
    endtask

    task automatic run_illegal(input int len);
        int            base_r, base_w;
        logic [DW-1:0] cs;
        base_r = ready_cnt;
        base_w = we_cnt;
        cs     = o_checksum;
        @(negedge clk);
        i_start = 1'b1;
        i_len   = (AW+1)'(len);
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        check_eq("illegal_err", o_err, 1);
        check_eq("illegal_busy", o_busy, 0);
        check_eq("illegal_done", o_done, 0);
        check_eq("illegal_cpu_rst", o_cpu_rst, 1);
        check_eq("illegal_checksum", o_checksum, cs);
        i_valid = 1'b1;
        i_data  = DW'($urandom);
        repeat (4) @(negedge clk);
        i_valid = 1'b0;
        check_eq("illegal_ready_seen", ready_cnt - base_r, 0);
        check_eq("illegal_we_seen", we_cnt - base_w, 0);
        check_eq("illegal_err_held", o_err, 1);
        $display("illegal len=%0d err=%0d", len, o_err);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_cpu_rst", o_cpu_rst, 1);
        check_eq("rst_checksum", o_checksum, 0);
        check_eq("rst_ready", o_ready, 0);
        check_eq("rst_we", o_we, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_done", o_done, 0);
        check_eq("rst_err", o_err, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_flags", {o_busy, o_done, o_err}, 0);

        wbuf[0] = 10'd5; wbuf[1] = 10'd10; wbuf[2] = 10'd15;
        run_load(3, 0, 1'b0, "b2b");
        run_load(3, 1, 1'b0, "toggle");

        wbuf[0] = 10'd1023; wbuf[1] = 10'd2;
        run_load(2, 0, 1'b0, "wrap");

        wbuf[0] = 10'd5; wbuf[1] = 10'd10; wbuf[2] = 10'd15;
        run_load(3, 0, 1'b1, "corrupt");
        run_load(3, 0, 1'b0, "reload");

        run_illegal(0);
        run_illegal(65);
        run_illegal(127);

        // Reset in the middle of a 4-word load.
        wbuf[0] = 10'd7; wbuf[1] = 10'd9; wbuf[2] = 10'd100; wbuf[3] = 10'd1000;
        @(negedge clk);
        i_start = 1'b1;
        i_len   = (AW+1)'(4);
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        for (int j = 0; j < 2; j++) begin
            i_valid = 1'b1;
            i_data  = wbuf[j];
            @(posedge clk);
            @(negedge clk);
        end
        i_valid = 1'b0;
        check_eq("midload_checksum", o_checksum, 16);
        #2 rst = 1'b0;
        #1;
        check_eq("async_rst_cpu_rst", o_cpu_rst, 1);
        check_eq("async_rst_checksum", o_checksum, 0);
        check_eq("async_rst_we", o_we, 0);
        check_eq("async_rst_ready", o_ready, 0);
        check_eq("async_rst_busy", o_busy, 0);
        check_eq("async_rst_addr", o_addr, 0);
        check_eq("async_rst_flags", {o_done, o_err}, 0);
        $display("async reset mid-load applied");
        @(negedge clk);
        rst = 1'b1;
        run_load(4, 0, 1'b0, "after_rst");

        wbuf[0] = DW'($urandom);
        run_load(1, 0, 1'b0, "len1");
        for (int j = 0; j < DEPTH; j++) wbuf[j] = DW'($urandom);
        run_load(DEPTH, 2, 1'b0, "len64");

        for (int t = 0; t < 10; t++) begin
            int len;
            bit cor;
            len = $urandom_range(1, DEPTH);
            cor = ($urandom_range(0, 3) == 0);
            for (int j = 0; j < DEPTH; j++) wbuf[j] = DW'($urandom);
            run_load(len, 2, cor, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
